// File: rtl/rf_wb_arb_if.sv
// Writeback arbiter bundle: ALU stream, handshaked long-latency stream, issue
// scoreboard updates, and the registered register-file write port.
interface rf_wb_arb_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [4:0]    alu_addr;
  logic [31:0]   alu_data;
  logic          lq_valid;
  logic          lq_ready;
  logic [4:0]    lq_addr;
  logic [31:0]   lq_data;
  logic          iss_valid;
  logic [4:0]    iss_addr;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          rf_src;
  logic          zero_drop;
  logic [31:0]   sb_busy;
  logic [CW-1:0] fifo_cnt;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lq_valid, lq_addr, lq_data,
    output iss_valid, iss_addr,
    input  lq_ready, rf_we, rf_waddr, rf_wdata, rf_src, zero_drop, sb_busy, fifo_cnt
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lq_valid, lq_addr, lq_data,
    input  iss_valid, iss_addr,
    output lq_ready, rf_we, rf_waddr, rf_wdata, rf_src, zero_drop, sb_busy, fifo_cnt
  );
endinterface

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: ALU beats long-latency FIFO, r0 writes are
// dropped, pending-write scoreboard for issue. RF_WB_BYPASS_EN enables idle bypass.
module rf_wb_arb #(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  rf_wb_arb_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          full, empty, xfer, push, pop;
  logic          sel_vld, sel_lq;
  wb_ent_t       sel;
  logic [31:0]   sb, sb_nxt;

  logic          we_q, src_q, drop_q;
  logic [4:0]    waddr_q;
  logic [31:0]   wdata_q;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign xfer  = bus.lq_valid && bus.lq_ready;

  assign bus.lq_ready  = rst_n && !full;
  assign bus.rf_we     = we_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.rf_src    = src_q;
  assign bus.zero_drop = drop_q;
  assign bus.sb_busy   = sb;
  assign bus.fifo_cnt  = cnt;

  // Fixed priority: ALU, then FIFO head, then (optionally) the incoming result.
  always_comb begin
    sel     = '{addr: bus.alu_addr, data: bus.alu_data};
    sel_vld = 1'b0;
    sel_lq  = 1'b0;
    pop     = 1'b0;
    push    = xfer;
    if (bus.alu_valid) begin
      sel_vld = 1'b1;
    end else if (!empty) begin
      pop     = 1'b1;
      sel_vld = 1'b1;
      sel_lq  = 1'b1;
      sel     = mem[rd_ptr];
    end
`ifdef RF_WB_BYPASS_EN
    else if (xfer) begin
      push    = 1'b0;
      sel_vld = 1'b1;
      sel_lq  = 1'b1;
      sel     = '{addr: bus.lq_addr, data: bus.lq_data};
    end
`endif
  end

  // Issue set is applied after writeback clear so it wins on a collision.
  always_comb begin
    sb_nxt = sb;
    if (sel_lq)
      sb_nxt[sel.addr] = 1'b0;
    if (bus.iss_valid)
      sb_nxt[bus.iss_addr] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{addr: bus.lq_addr, data: bus.lq_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      sb      <= '0;
      we_q    <= 1'b0;
      src_q   <= 1'b0;
      drop_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      cnt    <= cnt + CW'(push) - CW'(pop);
      sb     <= sb_nxt;
      we_q   <= sel_vld && (sel.addr != 5'd0);
      drop_q <= sel_vld && (sel.addr == 5'd0);
      src_q  <= sel_lq;
      if (sel_vld) begin
        waddr_q <= sel.addr;
        wdata_q <= sel.data;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arb.sv
// Randomized scoreboard bench for rf_wb_arb; the reference model is a queue of
// pending long-latency results plus a 32-bit pending mask.
module tb_rf_wb_arb;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arb_if #(.DEPTH(DEPTH)) bus();
  rf_wb_arb #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
    logic        src;
    logic        drop;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [31:0] sb;
    int          cnt;
    logic        rdy;
    logic        rstc;
  } st_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  wr_t         expq[$];
  st_t         stq[$];
  ent_t        mq[$];
  logic [31:0] msb = '0;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at edge %0d: got %h want %h", nm, cyc, act, exp);
  endtask

  // One clock of stimulus; the model predicts what the coming edge produces.
  task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ia, output logic x);
    wr_t  w;
    st_t  s;
    ent_t e;
    logic have, clr;
    @(negedge clk);
    rst_n = r;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.lq_valid  = lv; bus.lq_addr  = la; bus.lq_data  = ld;
    bus.iss_valid = iv; bus.iss_addr = ia;
    x = 1'b0; have = 1'b0; clr = 1'b0;
    w = '{cyc: 0, a: '0, d: '0, src: 1'b0, drop: 1'b0};
    if (!r) begin
      mq.delete();
      msb = '0;
    end else begin
      x = lv && (mq.size() != DEPTH);
      if (av) begin
        have = 1'b1; w.a = aa; w.d = ad; w.src = 1'b0;
        if (x) mq.push_back('{la, ld});
      end else if (mq.size() != 0) begin
        e = mq.pop_front();
        have = 1'b1; clr = 1'b1; w.a = e.a; w.d = e.d; w.src = 1'b1;
        if (x) mq.push_back('{la, ld});
      end else if (x) begin
`ifdef RF_WB_BYPASS_EN
        have = 1'b1; clr = 1'b1; w.a = la; w.d = ld; w.src = 1'b1;
`else
        mq.push_back('{la, ld});
`endif
      end
      if (have) begin
        w.cyc  = cyc + 1;
        w.drop = (w.a == 5'd0);
        expq.push_back(w);
      end
      if (clr) msb[w.a] = 1'b0;
      if (iv && ia != 5'd0) msb[ia] = 1'b1;
    end
    s.cyc = cyc + 1; s.sb = msb; s.cnt = mq.size();
    s.rdy = r && (mq.size() != DEPTH); s.rstc = !r;
    stq.push_back(s);
  endtask

  task automatic idle();
    logic x;
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, x);
  endtask

  // Monitor: compares state every edge and pops expected writes when the DUT writes.
  initial begin
    st_t s;
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (stq.size() != 0) begin
        s = stq.pop_front();
        if (s.cyc != cyc) check("state_align", 32'(cyc), 32'(s.cyc));
        else begin
          check("sb_busy", bus.sb_busy, s.sb);
          check("fifo_cnt", 32'(bus.fifo_cnt), 32'(s.cnt));
          check("lq_ready", 32'(bus.lq_ready), 32'(s.rdy));
          if (s.rstc) begin
            check("rst_we", 32'(bus.rf_we), 32'd0);
            check("rst_waddr", 32'(bus.rf_waddr), 32'd0);
            check("rst_wdata", bus.rf_wdata, 32'd0);
            check("rst_src", 32'(bus.rf_src), 32'd0);
            check("rst_drop", 32'(bus.zero_drop), 32'd0);
          end
        end
      end
      if (bus.rf_we === 1'b1 || bus.zero_drop === 1'b1) begin
        if (expq.size() == 0) check("unexpected_write", {30'd0, bus.rf_we, bus.zero_drop}, 32'd0);
        else begin
          e = expq.pop_front();
          check("wr_cycle", 32'(cyc), 32'(e.cyc));
          check("wr_kind", {30'd0, bus.rf_we, bus.zero_drop}, {30'd0, !e.drop, e.drop});
          if (!e.drop) begin
            check("wr_addr", 32'(bus.rf_waddr), 32'(e.a));
            check("wr_data", bus.rf_wdata, e.d);
            check("wr_src", 32'(bus.rf_src), 32'(e.src));
          end
        end
      end
    end
  end

  logic        lv = 1'b0;
  logic [4:0]  la = '0;
  logic [31:0] ld = '0;

  initial begin
    logic x;
    int   pct;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.lq_valid  = 1'b0; bus.lq_addr  = '0; bus.lq_data  = '0;
    bus.iss_valid = 1'b0; bus.iss_addr = '0;

    repeat (3) step(1'b0, 1'b1, 5'd9, 32'h1111, 1'b1, 5'd3, 32'h2222, 1'b1, 5'd4, x);
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, x);

    // Fill behind a busy ALU, then let it drain.
    for (int i = 1; i <= 4; i++)
      step(1'b1, 1'b1, 5'(10 + i), $urandom, 1'b1, 5'(i), 32'hA0 + 32'(i), 1'b0, 5'd0, x);
    step(1'b1, 1'b1, 5'd20, 32'h5555, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, x);
    repeat (6) idle();

    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD0, 1'b0, 5'd0, x);
    repeat (3) idle();

    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, x);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, x);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, x);
    repeat (2) idle();
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0, x);
    repeat (3) idle();

    pct = 50;
    for (int c = 0; c < 800; c++) begin
      logic       av, iv;
      logic [4:0] ia;
      if (c % 40 == 0) pct = $urandom_range(5, 95);
      av = ($urandom_range(0, 99) < pct);
      iv = ($urandom_range(0, 3) == 0);
      ia = 5'($urandom_range(0, 31));
      if (!lv && $urandom_range(0, 2) != 0) begin
        lv = 1'b1;
        la = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ld = $urandom;
      end
      if (c >= 400 && c < 402) begin
        step(1'b0, av, 5'($urandom), $urandom, lv, la, ld, iv, ia, x);
      end else begin
        step(1'b1, av, 5'($urandom_range(0, 31)), $urandom, lv, la, ld, iv, ia, x);
        if (x) lv = 1'b0;
      end
    end
    lv = 1'b0;
    repeat (12) idle();
    @(negedge clk);
    check("expq_empty", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
